// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial add/subtract datapath.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    localparam int NIB_BITS = 4;

endpackage

// File: rtl/carry_lookahead_adder_4_bit.sv
// 4-bit carry-lookahead slice with group propagate/generate outputs.
module carry_lookahead_adder_4_bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout,
    output logic       PG,
    output logic       GG
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = A ^ B;
    assign g = A & B;

    // Every carry is flattened to sum-of-products of p, g and Cin.
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = GG | (PG & Cin);

    assign PG   = &p;
    assign GG   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);

    assign Sum  = p ^ c[3:0];
    assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract that reuses one 4-bit CLA slice, one nibble per
// clock from LSB to MSB, with a registered carry between nibbles.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);

    localparam int NIB = WIDTH / NIB_BITS;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIB - 1);

    adder_state_t   state, state_d;
    logic [WIDTH-1:0] opa, opb, res;
    logic [WIDTH-1:0] eff_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             snap_a, snap_b;
    logic             cout_r, ovf_r;
    logic             last_nib;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    assign eff_b    = Sub ? ~B : B;
    assign last_nib = (cnt == LAST_CNT);

    carry_lookahead_adder_4_bit u_slice (
        .A    (opa[NIB_BITS-1:0]),
        .B    (opb[NIB_BITS-1:0]),
        .Cin  (carry),
        .Sum  (slice_sum),
        .Cout (slice_cout),
        .PG   (),
        .GG   ()
    );

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (Start) state_d = RUN;
            RUN:     if (last_nib) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            snap_a <= 1'b0;
            snap_b <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            state <= state_d;
            unique case (state)
                IDLE: if (Start) begin
                    opa    <= A;
                    opb    <= eff_b;
                    carry  <= Sub ? 1'b1 : Cin;
                    cnt    <= '0;
                    snap_a <= A[WIDTH-1];
                    snap_b <= eff_b[WIDTH-1];
                end
                RUN: begin
                    res   <= {slice_sum, res[WIDTH-1:NIB_BITS]};
                    opa   <= opa >> NIB_BITS;
                    opb   <= opb >> NIB_BITS;
                    carry <= slice_cout;
                    cnt   <= cnt + 1'b1;
                    // Carry into the MSB is recovered from the operand and result sign bits.
                    if (last_nib) begin
                        cout_r <= slice_cout;
                        ovf_r  <= slice_cout ^ (snap_a ^ snap_b ^ slice_sum[3]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Sum      = res;
    assign Cout     = cout_r;
    assign Overflow = ovf_r;
    assign Busy     = (state != IDLE);
    assign Done     = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: directed table, random ops against an arithmetic model,
// and hand sequences for Start-while-busy, Start held, and reset corners.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         Clk = 1'b0;
    logic         Reset, Start, Sub, Cin;
    logic [W-1:0] A, B;
    logic [W-1:0] Sum;
    logic         Cout, Overflow, Busy, Done;

    int n_cmp = 0;
    int n_bad = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Sub(Sub), .A(A), .B(B),
        .Cin(Cin), .Sum(Sum), .Cout(Cout), .Overflow(Overflow),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic         sub, cin;
        logic [W-1:0] sum;
        logic         cout, ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference: {overflow, carry, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic sub, cin);
        logic [W-1:0] eb;
        logic [W:0]   t;
        logic         ovf;
        eb  = sub ? ~b : b;
        t   = {1'b0, a} + {1'b0, eb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ovf = (a[W-1] == eb[W-1]) && (t[W-1] != a[W-1]);
        return {ovf, t};
    endfunction

    // Called at a negedge in IDLE; returns at the negedge where Done is seen.
    task automatic launch_and_wait(input logic [W-1:0] a, b, input logic sub, cin, output int lat);
        A = a; B = b; Sub = sub; Cin = cin; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        A = W'($urandom); B = W'($urandom); Sub = 1'($urandom); Cin = 1'($urandom);
        lat = 0;
        while (!Done && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
    endtask

    task automatic finish_op(input string name, input int lat, input logic [W-1:0] es,
                             input logic ec, input logic eo);
        logic [W-1:0] held;
        check({name, " latency"}, lat, NIB);
        check({name, " sum"}, Sum, es);
        check({name, " cout"}, Cout, ec);
        check({name, " ovf"}, Overflow, eo);
        held = Sum;
        @(negedge Clk);
        check({name, " done pulse"}, {Done, Busy}, 2'b00);
        check({name, " sum held"}, Sum, held);
    endtask

    initial begin
        int lat, gap, pulses;
        logic [W+1:0] m;
        logic [W-1:0] ra, rb;
        logic rs, rc;

        Reset = 1'b1; Start = 1'b0; Sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset busy", Busy, 1'b0);
        check("reset done", Done, 1'b0);
        check("reset sum", Sum, '0);
        check("reset cout/ovf", {Cout, Overflow}, 2'b00);
        Reset = 1'b0;
        @(negedge Clk);

        foreach (vecs[i]) begin
            launch_and_wait(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat);
            finish_op($sformatf("vec%0d", i), lat, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            m  = model(ra, rb, rs, rc);
            launch_and_wait(ra, rb, rs, rc, lat);
            finish_op($sformatf("rnd%0d", i), lat, m[W-1:0], m[W], m[W+1]);
        end

        // Start pulsed while in RUN must be dropped.
        A = 16'h1234; B = 16'h4321; Sub = 1'b0; Cin = 1'b0; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        A = 16'hAAAA; B = 16'h5555; Sub = 1'b1; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        lat = 3;
        while (!Done && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        finish_op("busy-start", lat, 16'h5555, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (Busy || Done) pulses++;
        end
        check("busy-start dropped", pulses, 0);

        // Start held high: one accepted op every IDLE+RUN+DONE = NIB+2 cycles.
        A = 16'h0001; B = 16'h0002; Sub = 1'b0; Cin = 1'b0; Start = 1'b1;
        lat = 0;
        @(negedge Clk);
        while (!Done && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        check("held first done", Done, 1'b1);
        gap = 0;
        pulses = 0;
        do begin
            @(negedge Clk);
            gap++;
        end while (!Done && gap < 20);
        Start = 1'b0;
        check("held done gap", gap, NIB + 2);
        check("held second sum", Sum, 16'h0003);
        @(negedge Clk);
        if (Done) pulses++;
        check("held single pulse", pulses, 0);

        // Reset on the 2nd RUN cycle aborts the operation.
        @(negedge Clk);
        A = 16'h1111; B = 16'h1111; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        check("pre-reset partial sum", Sum, 16'h2000);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midrun reset busy/done", {Busy, Done}, 2'b00);
        check("midrun reset sum", Sum, '0);
        check("midrun reset cout/ovf", {Cout, Overflow}, 2'b00);
        launch_and_wait(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        finish_op("post-reset", lat, 16'h8000, 1'b0, 1'b1);

        // Reset and Start together: nothing accepted.
        A = 16'h0F0F; B = 16'h0101; Start = 1'b1; Reset = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < NIB + 3; i++) begin
            @(negedge Clk);
            if (Busy || Done) pulses++;
        end
        check("reset+start ignored", pulses, 0);
        check("reset+start sum", Sum, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
